// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. It issues one instruction-memory request at a time,
// captures the response into the IF/ID pipeline register, and computes the
// next PC for the external program counter register. The unit also handles
// decode back-pressure through a one-entry skid register, and handles
// execute-stage redirects: it flushes IF/ID and drops a response that is
// still in flight.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous, active-high reset
//   pc_in          : current PC from the program counter register
//   pc_next        : combinational next PC to the program counter register
//   imem_req_valid : instruction-memory request valid
//   imem_req_ready : instruction memory accepts the request this cycle
//   imem_req_addr  : request address
//   imem_rsp_valid : response valid
//   imem_rsp_data  : response instruction word
//   branch_taken   : redirect and flush request from execute
//   branch_target  : redirect address
//   id_stall       : decode stall, holds IF/ID
//   ifid_valid     : IF/ID entry valid
//   ifid_pc        : PC of the IF/ID instruction
//   ifid_instr     : IF/ID instruction word (NOP_INSTR when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_in,
    output logic [63:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        id_stall,
    output logic        ifid_valid,
    output logic [63:0] ifid_pc,
    output logic [31:0] ifid_instr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] skid_q, skid_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [63:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        handshake;
    logic        adv_wait;
    logic        adv_hold;
    logic        advance;
    logic [63:0] pc_next_raw;
    logic        req_valid_raw;

    // A redirect always wins over an advance. Any instruction that would have
    // advanced in the same cycle belongs to the wrong path.
    assign handshake = (state_q == S_REQ) && imem_req_ready;
    assign adv_wait  = (state_q == S_WAIT) && imem_rsp_valid && !id_stall && !branch_taken;
    assign adv_hold  = (state_q == S_HOLD) && !id_stall && !branch_taken;
    assign advance   = adv_wait || adv_hold;

    // The request address is simply the current PC. It is only meaningful
    // while imem_req_valid is high.
    assign imem_req_addr = pc_in;

    // Next-state and next-PC logic
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        skid_d        = skid_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        req_valid_raw = (state_q == S_REQ);

        // The adder is 64 bits wide, so it wraps from ...FFFC to 0 on its own.
        if (branch_taken) begin
            pc_next_raw = branch_target;
        end else if (advance) begin
            pc_next_raw = fetch_pc_q + 64'd4;
        end else begin
            pc_next_raw = pc_in;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (handshake) begin
                    fetch_pc_d = pc_in;
                    // A request accepted together with a redirect is on the
                    // wrong path. Its response must still be absorbed.
                    state_d    = branch_taken ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (branch_taken) begin
                    // If the stale beat arrives in the redirect cycle, there is
                    // nothing left to drain.
                    state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (imem_rsp_valid) begin
                    if (id_stall) begin
                        skid_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken || !id_stall) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A redirect discards whatever the skid register was parked on.
        if (branch_taken) begin
            skid_d = 32'd0;
        end

        // IF/ID update, highest priority first: flush, advance, bubble, hold.
        if (branch_taken) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (advance) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = fetch_pc_q;
            ifid_instr_d = adv_wait ? imem_rsp_data : skid_q;
        end else if (!id_stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    // While reset is high the PC register is steered to 0, and no request is
    // offered to memory.
    assign pc_next        = reset ? 64'd0 : pc_next_raw;
    assign imem_req_valid = reset ? 1'b0 : req_valid_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= 64'd0;
            skid_q       <= 32'd0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 64'd0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            skid_q       <= skid_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_pc    = ifid_pc_q;
    assign ifid_instr = ifid_instr_q;

endmodule
